uart_receiver: RTL and testbench

- UART receive path, the counterpart of the team's UART transmitter; same frame options (frame length, parity enable/type, 1 or 2 stop bits).
- Recovers start, data, parity and stop bits from the serial line using an oversampled tick clock.
- Presents each received byte with a one-cycle done strobe and per-frame error flags to the host-side logic.

---
 rtl/uart_receiver.sv | 156 +++++++++++++++
 tb/tb_uart_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: 2-flop synchroniser, mid-bit sampling on an oversampled tick,
// with configurable data length, parity and stop bits, and per-frame error flags.
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       rx_tick,
  input  logic       reset,
  input  logic       rx,
  input  logic [3:0] frame_length,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       stop2,
  output logic [7:0] rx_dout,
  output logic       rx_done,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_reg;
  logic            rx_meta_reg;
  logic            rx_s_reg;
  logic            rx_prev_reg;
  logic [TW-1:0]   tick_reg;
  logic [2:0]      bit_reg;
  logic [2:0]      last_bit_reg;
  logic            par_en_reg;
  logic            par_type_reg;
  logic            stop2_reg;
  logic            stop_cnt_reg;
  logic [7:0]      shift_reg;
  logic            par_acc_reg;
  logic            perr_reg;
  logic            ferr_reg;

  logic [2:0] len_m1;
  logic       bit_tick;

  // Out-of-range lengths fall back to a full byte.
  assign len_m1   = (frame_length == 4'd0 || frame_length > 4'd8) ? 3'd7 : 3'(frame_length - 4'd1);
  assign bit_tick = (tick_reg == TICK_LAST);

  always_ff @(posedge rx_tick or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rx_meta_reg  <= 1'b1;
      rx_s_reg     <= 1'b1;
      rx_prev_reg  <= 1'b1;
      tick_reg     <= '0;
      bit_reg      <= '0;
      last_bit_reg <= '0;
      par_en_reg   <= 1'b0;
      par_type_reg <= 1'b0;
      stop2_reg    <= 1'b0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      par_acc_reg  <= 1'b0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      rx_dout      <= '0;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
      rx_done     <= 1'b0;

      case (state_reg)
        IDLE: begin
          // Edge-triggered arming, so a held-low line cannot re-trigger.
          if (rx_prev_reg && !rx_s_reg) begin
            state_reg <= START;
            tick_reg  <= '0;
          end
        end

        START: begin
          if (tick_reg == TICK_MID) begin
            tick_reg <= '0;
            if (rx_s_reg) begin
              state_reg <= IDLE;
            end else begin
              last_bit_reg <= len_m1;
              par_en_reg   <= parity_en;
              par_type_reg <= parity_type;
              stop2_reg    <= stop2;
              bit_reg      <= '0;
              shift_reg    <= '0;
              par_acc_reg  <= 1'b0;
              perr_reg     <= 1'b0;
              ferr_reg     <= 1'b0;
              state_reg    <= DATA;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_tick) begin
            tick_reg           <= '0;
            shift_reg[bit_reg] <= rx_s_reg;
            par_acc_reg        <= par_acc_reg ^ rx_s_reg;
            if (bit_reg == last_bit_reg) begin
              stop_cnt_reg <= 1'b0;
              state_reg    <= par_en_reg ? PARITY : STOP;
            end else begin
              bit_reg <= bit_reg + 3'd1;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end

        PARITY: begin
          if (bit_tick) begin
            tick_reg  <= '0;
            perr_reg  <= par_acc_reg ^ rx_s_reg ^ par_type_reg;
            state_reg <= STOP;
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end

        STOP: begin
          if (bit_tick) begin
            tick_reg <= '0;
            if (!rx_s_reg) ferr_reg <= 1'b1;
            // Report at the last stop midpoint and re-arm half a bit early.
            if (stop_cnt_reg == stop2_reg) begin
              rx_dout      <= shift_reg;
              parity_error <= perr_reg;
              frame_error  <= ferr_reg | ~rx_s_reg;
              rx_done      <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are generated from a behavioural
// model, expectations queued, and a monitor checks every rx_done strobe.
module tb_uart_receiver;

  localparam int OS = 16;

  logic       rx_tick = 1'b0;
  logic       reset   = 1'b1;
  logic       rx      = 1'b1;
  logic [3:0] frame_length = 4'd8;
  logic       parity_en    = 1'b0;
  logic       parity_type  = 1'b0;
  logic       stop2        = 1'b0;
  logic [7:0] rx_dout;
  logic       rx_done;
  logic       parity_error;
  logic       frame_error;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .rx_tick      (rx_tick),
    .reset        (reset),
    .rx           (rx),
    .frame_length (frame_length),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .stop2        (stop2),
    .rx_dout      (rx_dout),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .frame_error  (frame_error)
  );

  always #5 rx_tick = ~rx_tick;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  int   frame_start_cyc = 0;
  logic prev_done = 1'b0;
  logic [7:0] last_dout = 8'h00;

  always @(posedge rx_tick) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per rx_done strobe.
  always @(negedge rx_tick) begin
    if (!reset && rx_done) begin
      exp_t e;
      done_count++;
      last_done_cyc = cyc;
      $display("rx frame: dout=%02h parity_error=%b frame_error=%b at cycle %0d",
               rx_dout, parity_error, frame_error, cyc);
      check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("rx_dout", {24'd0, rx_dout}, {24'd0, e.d});
        check("parity_error", {31'd0, parity_error}, {31'd0, e.pe});
        check("frame_error", {31'd0, frame_error}, {31'd0, e.fe});
        last_dout = e.d;
      end
    end
    prev_done = rx_done;
  end

  // Drives one frame and queues the expected result derived from the frame rules.
  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                            input logic ptype, input logic s2, input logic flip,
                            input logic stop_low, input int gap_bits);
    int   n;
    int   ones;
    logic pbit;
    exp_t e;
    n = (nbits == 0 || nbits > 8) ? 8 : nbits;
    ones = 0;
    e.d = 8'h00;
    for (int i = 0; i < n; i++) begin
      e.d[i] = data[i];
      if (data[i]) ones++;
    end
    // Correct parity bit makes the total count even (ptype=0) or odd (ptype=1).
    pbit = ((ones % 2) != int'(ptype)) ^ flip;
    e.pe = pen && (((ones + int'(pbit)) % 2) != int'(ptype));
    e.fe = stop_low;
    q.push_back(e);
    @(negedge rx_tick);
    frame_length = 4'(nbits);
    parity_en    = pen;
    parity_type  = ptype;
    stop2        = s2;
    rx = 1'b0;
    frame_start_cyc = cyc;
    repeat (OS) @(negedge rx_tick);
    for (int i = 0; i < n; i++) begin
      rx = data[i];
      repeat (OS) @(negedge rx_tick);
    end
    if (pen) begin
      rx = pbit;
      repeat (OS) @(negedge rx_tick);
    end
    for (int s = 0; s < (s2 ? 2 : 1); s++) begin
      rx = ~stop_low;
      repeat (OS) @(negedge rx_tick);
    end
    if (gap_bits > 0) begin
      rx = 1'b1;
      repeat (gap_bits * OS) @(negedge rx_tick);
    end
  endtask

  task automatic idle_bits(input int nb);
    rx = 1'b1;
    repeat (nb * OS) @(negedge rx_tick);
  endtask

  initial begin
    int dc;
    repeat (3) @(negedge rx_tick);
    check("reset_dout", {24'd0, rx_dout}, 32'd0);
    check("reset_done", {31'd0, rx_done}, 32'd0);
    check("reset_perr", {31'd0, parity_error}, 32'd0);
    check("reset_ferr", {31'd0, frame_error}, 32'd0);
    reset = 1'b0;
    idle_bits(2);

    // 8N1 0xA5 with latency measurement (2 + 9.5*16 + 1 = 155 cycles).
    send_frame(8'hA5, 8, 0, 0, 0, 0, 0, 2);
    check("latency_window", {31'd0, ((last_done_cyc - frame_start_cyc) >= 154 &&
                                     (last_done_cyc - frame_start_cyc) <= 156)}, 32'd1);
    check("count_after_a5", done_count, 32'd1);

    // 7E2: good parity then forced-wrong parity bit.
    send_frame(8'h55, 7, 1, 0, 1, 0, 0, 1);
    send_frame(8'h55, 7, 1, 0, 1, 1, 0, 1);
    // 5O1: right-aligned data, upper bits masked.
    send_frame(8'h1F, 5, 1, 1, 0, 0, 0, 1);
    send_frame(8'h3F, 5, 1, 1, 0, 0, 0, 1);

    // Stop bit low, then a 40-bit break: only the one frame reports.
    send_frame(8'h96, 8, 0, 0, 0, 0, 1, 0);
    rx = 1'b0;
    dc = done_count;
    repeat (40 * OS) @(negedge rx_tick);
    idle_bits(2);
    check("break_no_retrigger", done_count, dc);
    send_frame(8'h11, 8, 0, 0, 0, 0, 0, 1);

    // Glitch shorter than half a bit is rejected with outputs held.
    dc = done_count;
    @(negedge rx_tick);
    rx = 1'b0;
    repeat (5) @(negedge rx_tick);
    idle_bits(2);
    check("glitch_no_done", done_count, dc);
    check("glitch_dout_held", {24'd0, rx_dout}, {24'd0, last_dout});
    send_frame(8'h3C, 8, 0, 0, 0, 0, 0, 1);

    // Back-to-back frames with no idle gap.
    send_frame(8'h01, 8, 0, 0, 0, 0, 0, 0);
    send_frame(8'hFE, 8, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of the data bits of 0x81.
    @(negedge rx_tick);
    rx = 1'b0;
    repeat (OS) @(negedge rx_tick);
    rx = 1'b1;
    repeat (OS + 4) @(negedge rx_tick);
    rx = 1'b0;
    repeat (OS) @(negedge rx_tick);
    reset = 1'b1;
    #1;
    check("midreset_dout", {24'd0, rx_dout}, 32'd0);
    check("midreset_done", {31'd0, rx_done}, 32'd0);
    rx = 1'b1;
    repeat (3) @(negedge rx_tick);
    reset = 1'b0;
    dc = done_count;
    idle_bits(10);
    check("midreset_no_partial", done_count, dc);
    send_frame(8'h42, 8, 0, 0, 0, 0, 0, 1);

    // frame_length changes mid-frame; the latched length must stay 8.
    fork
      send_frame(8'hB7, 8, 0, 0, 0, 0, 0, 1);
      begin
        repeat (4 * OS) @(negedge rx_tick);
        frame_length = 4'd5;
      end
    join

    // Randomized frames; out-of-range lengths included.
    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      int   nb;
      logic sl;
      d  = 8'($urandom);
      nb = $urandom_range(0, 15);
      sl = ($urandom_range(0, 5) == 0);
      send_frame(d, nb, 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), sl, $urandom_range(1, 3));
    end

    idle_bits(4);
    check("queue_drained", q.size(), 32'd0);
    check("total_frames", done_count, 32'd36);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
